// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Purpose:
//   Time-multiplexes NUM_DIGITS hex nibbles onto one shared active-low
//   seven-segment bus. It provides the following features:
//     - a programmable slot length (SCAN_DIV cycles per digit);
//     - a one-cycle dead slot at every digit change, to prevent ghosting;
//     - per-digit blanking;
//     - frame-synchronous loading, so a frame never shows a mix of old and
//       new values.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (1..16)
//   SCAN_DIV    clock cycles per digit slot (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   digits_in   4*NUM_DIGITS hex nibbles, digit k = bits [4k+3:4k]
//   load        capture digits_in into the pending register on this edge
//   blank_mask  bit k = 1 keeps digit k dark (sampled every cycle)
//   my_display  segments {g,f,e,d,c,b,a}, active-low, registered
//   my_digit    one-hot digit enable, active-low, registered
//   frame_tick  one-cycle pulse in the first cycle of each frame
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When the macro is defined, each digit k > 0 is also darkened when
//   active[k] and every higher nibble are zero. Digit 0 is always shown.
//   This blanking is ORed with blank_mask.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              my_display,
  output logic [NUM_DIGITS-1:0]   my_digit,
  output logic                    frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  // Scan state and the two display buffers.
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;
  logic                    pend_valid;

  // Next-state values. The outputs are registered from these, so the pins
  // line up with the scan position that the registers hold.
  logic [CW-1:0]           cnt_n;
  logic [IW-1:0]           idx_n;
  logic [4*NUM_DIGITS-1:0] active_n;
  logic                    cnt_wrap;
  logic                    frame_edge;

  always_comb begin
    cnt_wrap = (cnt == CNT_MAX);
    cnt_n    = cnt_wrap ? '0 : cnt + 1'b1;
    idx_n    = idx;
    if (NUM_DIGITS > 1) begin
      if (cnt_wrap) begin
        idx_n = (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
    end else begin
      idx_n = '0;
    end
    // With a single digit, idx is always IDX_MAX (0), so every slot wrap
    // is also a frame boundary.
    frame_edge = cnt_wrap && (idx == IDX_MAX);
    active_n   = (frame_edge && pend_valid) ? pending : active;
  end

  // Split the next active value into nibbles so it can be indexed by digit.
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
    assign nib[k] = active_n[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 0) begin : g_lz0
      assign lz_blank[k] = 1'b0;
    end else begin : g_lzk
      // Darken the digit when it and every more significant nibble are zero.
      assign lz_blank[k] = ~|active_n[4*NUM_DIGITS-1:4*k];
    end
`else
    assign lz_blank[k] = 1'b0;
`endif
  end

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [3:0] cur_nib;
  logic       dark_n;

  always_comb begin
    cur_nib = nib[idx_n];
    // A blanked slot looks exactly like a dead slot. The scan timing does
    // not change.
    dark_n  = (cnt_n == '0) || blank_mask[idx_n] || lz_blank[idx_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      active     <= '0;
      pend_valid <= 1'b0;
      my_digit   <= '1;
      my_display <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      idx    <= idx_n;
      active <= active_n;
      // A load on the boundary edge still lands in pending. The boundary
      // has already moved the old pending value into active.
      if (load) begin
        pending <= digits_in;
      end
      pend_valid <= load || (pend_valid && !frame_edge);
      frame_tick <= frame_edge;
      my_digit   <= dark_n ? '1 : ~(DIG_ONE << idx_n);
      my_display <= dark_n ? 7'h7F : decode(cur_nib);
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised successor to the fixed four-digit seven-segment player. Multiplexes NUM_DIGITS hex nibbles onto one shared active-low segment bus, with a programmable scan rate, a one-cycle anti-ghosting dead slot at every digit change, per-digit blanking, and tear-free frame-synchronous loading. Sits between the application datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..16.
SCAN_DIV, 1000, clock cycles per digit slot; legal range >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
digits_in  input  4*NUM_DIGITS  hex nibbles; digit k = bits [4k+3:4k]; digit 0 is rightmost/least significant.
load  input  1  on a rising clk edge with load=1, capture digits_in into the pending register.
blank_mask  input  NUM_DIGITS  bit k=1 keeps digit k dark; sampled live, every cycle.
my_display  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
my_digit  output  NUM_DIGITS  one-hot digit enable, active-low, registered.
frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- State: scan counter cnt (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1), pending register, active register, and a pend_valid flag.
- Reset: cnt=0, idx=0, pending=0, active=0, pend_valid=0, my_digit=all 1s, my_display=7'h7F, frame_tick=0.
- Scan counter: each non-reset edge increments cnt. When cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Outputs are registered from the next-state values of cnt and idx.
- Dead slot: in any cycle with cnt==0, my_digit=all 1s and my_display=7'h7F.
- Enabled digit: in any cycle with cnt!=0, my_digit[idx]=0 and all other bits are 1. my_display=decode(active[idx]).
- First visible digit: digit 0 is first enabled on the first edge after rst deasserts.
- Frame timing: each digit is lit for SCAN_DIV-1 cycles. One frame is NUM_DIGITS*SCAN_DIV cycles.
- Blanking: if blank_mask[idx]=1, the slot behaves like a dead slot (all enables off, segments 7'h7F). Scan timing is unchanged.
- Decode (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Load:
  - On a load edge, pending<=digits_in and pend_valid<=1.
  - Repeated loads before a frame boundary overwrite pending; the last one wins.
- Frame boundary: the edge where idx wraps to 0 with cnt becoming 0.
  - If pend_valid=1, active<=pending and pend_valid<=0.
  - frame_tick is 1 for exactly that cycle.
  - The displayed value never changes mid-frame.
- Load coinciding with the frame boundary: the boundary transfers the old pending value. The new digits_in goes to pending with pend_valid=1, and displays from the following frame.
- NUM_DIGITS=1: idx is constant 0, and every slot is a frame boundary.
- Reset mid-operation: returns to the reset state on that edge and discards pending.

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN
- Defined: any digit k>0 is treated as blanked when active[k] and all higher-indexed active nibbles are 0. Digit 0 is never suppressed by this rule. This is ORed with blank_mask.
- Undefined: zeros display as "0". Only blank_mask blanks.

Test Plan:
Use NUM_DIGITS=4, SCAN_DIV=4 unless noted.
- Reset: hold rst=1 for 3 edges -> my_digit=4'hF, my_display=7'h7F, frame_tick=0. First edge after release -> my_digit=4'hE, my_display=7'h40.
- Load and frame sync: load=1 with digits_in=16'h3210 mid-frame -> old value held until the next frame_tick. Next frame shows digits 0..3 as 40,79,24,30 on enables E,D,B,7, each for 3 cycles with a 1-cycle F/7F gap between. frame_tick period is 16 cycles.
- Blanking: blank_mask=4'b0100 with 16'h3210 -> digit 2's slot shows my_digit=F and my_display=7F. Other digits are unchanged.
- Load races: loads of 16'hAAAA then 16'hBBBB in one frame -> next frame shows b on every digit. A load on the frame_tick edge -> its value appears one frame later.
- Reset mid-frame: assert rst during digit 2 of a pending load -> outputs blank. After release, digit 0 shows 7'h40 (active=0) and the pending value is gone.
- LEADING_ZERO_BLANK_EN defined: load 16'h0050 -> digits 3 and 2 dark, digit 1 shows 7'h12, digit 0 shows 7'h40. Load 16'h0000 -> only digit 0 lit, showing 7'h40.
